regfile_wb_arb: RTL
===================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock; the register file samples writes on the following falling edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port hold, input, 1 bit: pipeline stall; no grants while high.
REQ-004 SHALL have ports req_valid[2:0], input, 3 bits: write request per source (0=ALU, 1=load unit, 2=mul/div unit).
REQ-005 SHALL have ports req_addr0/1/2, input, 5 bits each: destination register per source.
REQ-006 SHALL have ports req_data0/1/2, input, 32 bits each: write data per source.
REQ-007 SHALL have port req_ready[2:0], output, 3 bits: one-hot accept; transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-008 SHALL have port rf_ena, output, 1 bit: register-file enable; constant 1 except during reset (0).
REQ-009 SHALL have port rf_we, output, 1 bit: register-file write enable.
REQ-010 SHALL have port rf_waddr, output, 5 bits: register-file write address (rdc).
REQ-011 SHALL have port rf_wdata, output, 32 bits: register-file write data (rd).
REQ-012 SHALL have port pend_mask, output, 32 bits: bit k high when register k has a write that is requested or in flight and not yet committed.
REQ-013 SHALL have port wb_count, output, 16 bits: count of committed nonzero-address writes.

Function
REQ-014 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid, hold and the priority pointer.
REQ-015 SHALL assert req_ready only when hold is 0; req_ready is 0 for every source whose req_valid is 0.
REQ-016 SHALL arbitrate round-robin using a 2-bit last-grant pointer: search order is last+1, last+2, last (mod 3); the pointer updates to the granted index on each transfer only.
REQ-017 SHALL register an accepted request into a single output stage at the rising edge of acceptance (cycle N), presenting rf_we/rf_waddr/rf_wdata for exactly cycle N+1 (latency 1, throughput 1 write/cycle).
REQ-018 SHALL drive rf_we=0 in a cycle following no transfer; rf_waddr/rf_wdata hold their last values.
REQ-019 SHALL accept and consume a request with address 0 but drive rf_we=0 for it; it does not increment wb_count and does not set pend_mask bit 0.
REQ-020 SHALL change outputs only on rising edges so they are stable at the register file's falling-edge sample.
REQ-021 SHALL compute pend_mask as OR of: decoded req_addr[i] for each valid i, and decoded rf_waddr when rf_we=1; bit 0 is always 0.
REQ-022 SHALL increment wb_count by 1 in each cycle where a nonzero-address write is registered into the output stage, wrapping from 16'hFFFF to 0.
REQ-023 SHALL, with hold asserted mid-stream, still present an already registered write (rf_we=1 in the next cycle) while granting nothing new.
REQ-024 SHALL leave two sources requesting the same address to be committed in grant order; the later grant overwrites.
REQ-025 SHALL not require requesters to hold data stable after the accepting edge.

Reset
REQ-026 SHALL, while rst=1, force rf_ena=0, rf_we=0, rf_waddr=0, rf_wdata=0, req_ready=0, wb_count=0 and last-grant pointer=2 (source 0 first priority).
REQ-027 SHALL discard any in-flight write on reset assertion; the first grant after deassertion occurs on the first rising edge with rst=0.

Verification
REQ-028 Bench SHALL check: source 1 only, addr 5, data 32'hDEADBEEF at edge N -> req_ready=3'b010 in cycle N; rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF in cycle N+1; wb_count=1.
REQ-029 Bench SHALL check: all three valid continuously for 6 cycles after reset -> grant order 0,1,2,0,1,2; rf_we high 6 consecutive cycles.
REQ-030 Bench SHALL check: source 2 writes addr 0, data 32'h1234 -> req_ready[2]=1, next cycle rf_we=0, wb_count unchanged, pend_mask=0.
REQ-031 Bench SHALL check: hold=1 with source 0 valid (addr 7) for 3 cycles -> req_ready=0, pend_mask=32'h80; hold drops -> write of addr 7 the following cycle.
REQ-032 Bench SHALL check: rst pulsed in the cycle after a grant -> rf_we=0 immediately, wb_count=0, next grant goes to source 0 when all three request.
REQ-033 Bench SHALL check: wb_count preset via 65535 writes -> the next nonzero-address write wraps wb_count to 0.

Source files
------------

// File: rtl/regfile_wb_arb.sv
// Write-back arbiter: round-robin selection among ALU, load and mul/div results
// into a single registered register-file write port, with pending-write tracking.
module regfile_wb_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [2:0]  req_valid,
    input  logic [4:0]  req_addr0,
    input  logic [4:0]  req_addr1,
    input  logic [4:0]  req_addr2,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    input  logic [31:0] req_data2,
    output logic [2:0]  req_ready,
    output logic        rf_ena,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pend_mask,
    output logic [15:0] wb_count
);

    logic [1:0]  last_r;
    logic        rf_ena_r;
    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [31:0] rf_wdata_r;
    logic [15:0] wb_count_r;

    logic [1:0]  c1_s;
    logic [1:0]  c2_s;
    logic [2:0]  grant_s;
    logic [1:0]  gidx_s;
    logic        xfer_s;
    logic [4:0]  sel_addr_s;
    logic [31:0] sel_data_s;
    logic [31:0] pend_s;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        case (v)
            2'd0:    inc3 = 2'd1;
            2'd1:    inc3 = 2'd2;
            default: inc3 = 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] dec5(input logic [4:0] a);
        dec5 = 32'd1 << a;
    endfunction

    // Round-robin grant: search last+1, last+2, then last itself.
    always_comb begin
        c1_s    = inc3(last_r);
        c2_s    = inc3(c1_s);
        grant_s = 3'b000;
        gidx_s  = last_r;
        if (rst || hold) begin
            grant_s = 3'b000;
        end else if (req_valid[c1_s]) begin
            grant_s = 3'b001 << c1_s;
            gidx_s  = c1_s;
        end else if (req_valid[c2_s]) begin
            grant_s = 3'b001 << c2_s;
            gidx_s  = c2_s;
        end else if (req_valid[last_r]) begin
            grant_s = 3'b001 << last_r;
            gidx_s  = last_r;
        end else begin
            grant_s = 3'b000;
        end
    end

    assign xfer_s = |grant_s;

    // Select the winning source's address and data.
    always_comb begin
        case (gidx_s)
            2'd0: begin
                sel_addr_s = req_addr0;
                sel_data_s = req_data0;
            end
            2'd1: begin
                sel_addr_s = req_addr1;
                sel_data_s = req_data1;
            end
            default: begin
                sel_addr_s = req_addr2;
                sel_data_s = req_data2;
            end
        endcase
    end

    // Registers requested plus in-flight destinations; r0 is never pending.
    always_comb begin
        pend_s = (req_valid[0] ? dec5(req_addr0)  : 32'd0)
               | (req_valid[1] ? dec5(req_addr1)  : 32'd0)
               | (req_valid[2] ? dec5(req_addr2)  : 32'd0)
               | (rf_we_r      ? dec5(rf_waddr_r) : 32'd0);
        pend_s[0] = 1'b0;
    end

    // Output stage, grant pointer and commit counter; writes to r0 are consumed silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r     <= 2'd2;
            rf_ena_r   <= 1'b0;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= 32'd0;
            wb_count_r <= 16'd0;
        end else begin
            rf_ena_r <= 1'b1;
            if (xfer_s) begin
                last_r     <= gidx_s;
                rf_we_r    <= (sel_addr_s != 5'd0);
                rf_waddr_r <= sel_addr_s;
                rf_wdata_r <= sel_data_s;
                if (sel_addr_s != 5'd0) begin
                    wb_count_r <= wb_count_r + 16'd1;
                end
            end else begin
                rf_we_r <= 1'b0;
            end
        end
    end

    assign req_ready = grant_s;
    assign rf_ena    = rf_ena_r;
    assign rf_we     = rf_we_r;
    assign rf_waddr  = rf_waddr_r;
    assign rf_wdata  = rf_wdata_r;
    assign pend_mask = pend_s;
    assign wb_count  = wb_count_r;

endmodule
